// File: rtl/ccc_cfg_pkg.sv
// Shared types for the CCC reconfiguration controller:
// FSM state encoding and table-entry field layout.
package ccc_cfg_pkg;

  localparam int CCC_ADDR_W = 6;
  localparam int CCC_DATA_W = 8;
  localparam int TBL_W      = 15;
  localparam int LAST_BIT   = 14;
  localparam int ADDR_HI    = 13;
  localparam int ADDR_LO    = 8;
  localparam int DATA_HI    = 7;
  localparam int DATA_LO    = 0;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK,
    ST_RUN,
    ST_HOLD,
    ST_FETCH,
    ST_SETUP,
    ST_ACCESS,
    ST_RSETUP,
    ST_RACCESS,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/lock_filter.sv
// PLL LOCK synchronizer and stability counter.
// Ports: clk/rst, lock_async in, clr in; lock_stable, lock_sync_low out.
module lock_filter #(
  parameter int LOCK_STABLE = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_async,
  input  logic clr,
  output logic lock_stable,
  output logic lock_sync_low
);

  localparam int CW = $clog2(LOCK_STABLE + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier consecutive sync-high
  // cycles, so the current cycle completes the run at L-1.
  always_comb begin
    meta_d = lock_async;
    sync_d = meta_q;
    cnt_d  = cnt_q;
    if (clr || !sync_q)
      cnt_d = '0;
    else if (cnt_q != CW'(LOCK_STABLE))
      cnt_d = cnt_q + 1'b1;
  end

  assign lock_stable   = sync_q && !clr &&
                         (cnt_q >= CW'(LOCK_STABLE - 1));
  assign lock_sync_low = !sync_q;

endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// CCC dynamic-config sequencer: writes a profile table over APB,
// optional readback, then waits for stable LOCK and releases fabric.
module ccc_reconfig_ctrl
  import ccc_cfg_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int ENTRY_W      = 4,
  parameter int VERIFY       = 1,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  localparam int PW          = $clog2(NUM_PROFILES)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ,
  input  logic [PW-1:0]         PROFILE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  LOCK_LOST,
  output logic                  FABRIC_RST,
  output logic [PW+ENTRY_W-1:0] TBL_ADDR,
  input  logic [TBL_W-1:0]      TBL_DATA,
  output logic                  CCC_PSEL,
  output logic                  CCC_PENABLE,
  output logic                  CCC_PWRITE,
  output logic [CCC_ADDR_W-1:0] CCC_PADDR,
  output logic [CCC_DATA_W-1:0] CCC_PWDATA,
  input  logic [CCC_DATA_W-1:0] CCC_PRDATA,
  output logic                  CCC_PRESET_N,
  output logic                  CCC_PLL_ARST_N,
  input  logic                  CCC_LOCK
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      prof_q, prof_d;
  logic [ENTRY_W-1:0] idx_q, idx_d;
  logic [TBL_W-1:0]   ent_q, ent_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               done_q, done_d;
  logic               lost_q, lost_d;
  logic               preset_n_q;

  logic               lock_stable, lock_sync_low;
  logic               last_ent, xfer, wr_phase;
  state_e             next_ent;
  logic [ADDR_HI:0]   ent_cur;

  lock_filter #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock (
    .clk          (CLK),
    .rst          (RESET),
    .lock_async   (CCC_LOCK),
    .clr          (!(state_q == ST_WAIT_LOCK ||
                     state_q == ST_RUN)),
    .lock_stable  (lock_stable),
    .lock_sync_low(lock_sync_low)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_WAIT_LOCK;
      prof_q     <= '0;
      idx_q      <= '0;
      ent_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      preset_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prof_q     <= prof_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
      preset_n_q <= 1'b1;
    end
  end

  assign last_ent = ent_q[LAST_BIT] || (idx_q == '1);
  assign next_ent = last_ent ? ST_WAIT_LOCK : ST_FETCH;

  always_comb begin
    state_d = state_q;
    prof_d  = prof_q;
    idx_d   = idx_q;
    ent_d   = ent_q;
    tmo_d   = '0;
    done_d  = 1'b0;
    lost_d  = lost_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_stable) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else if (tmo_q >= TW'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      // REQ outranks a same-cycle lock drop.
      ST_RUN: begin
        if (REQ) begin
          prof_d  = PROFILE;
          lost_d  = 1'b0;
          state_d = ST_HOLD;
        end else if (lock_sync_low) begin
          lost_d  = 1'b1;
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        idx_d   = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_SETUP;
      ST_SETUP: begin
        ent_d   = TBL_DATA;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (VERIFY != 0) begin
          state_d = ST_RSETUP;
        end else begin
          state_d = next_ent;
          if (!last_ent) idx_d = idx_q + 1'b1;
        end
      end
      ST_RSETUP: state_d = ST_RACCESS;
      ST_RACCESS: begin
        if (CCC_PRDATA != ent_q[DATA_HI:DATA_LO]) begin
          state_d = ST_FAIL;
        end else begin
          state_d = next_ent;
          if (!last_ent) idx_d = idx_q + 1'b1;
        end
      end
      ST_FAIL: begin
        if (REQ) begin
          prof_d  = PROFILE;
          lost_d  = 1'b0;
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Table data arrives during SETUP; later phases use the copy.
  assign ent_cur  = (state_q == ST_SETUP) ?
                    TBL_DATA[ADDR_HI:0] : ent_q[ADDR_HI:0];
  assign xfer     = state_q == ST_SETUP  ||
                    state_q == ST_ACCESS ||
                    state_q == ST_RSETUP ||
                    state_q == ST_RACCESS;
  assign wr_phase = state_q == ST_SETUP ||
                    state_q == ST_ACCESS;

  assign TBL_ADDR       = {prof_q, idx_q};
  assign CCC_PSEL       = xfer;
  assign CCC_PENABLE    = state_q == ST_ACCESS ||
                          state_q == ST_RACCESS;
  assign CCC_PWRITE     = wr_phase;
  assign CCC_PADDR      = xfer ? ent_cur[ADDR_HI:ADDR_LO] : '0;
  assign CCC_PWDATA     = wr_phase ?
                          ent_cur[DATA_HI:DATA_LO] : '0;
  assign CCC_PRESET_N   = preset_n_q;
  assign CCC_PLL_ARST_N = !(xfer || state_q == ST_HOLD ||
                            state_q == ST_FETCH);
  assign FABRIC_RST     = state_q != ST_RUN;
  assign BUSY           = !(state_q == ST_RUN ||
                            state_q == ST_FAIL);
  assign ERR            = state_q == ST_FAIL;
  assign DONE           = done_q;
  assign LOCK_LOST      = lost_q;

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Self-checking bench for ccc_reconfig_ctrl: random tables,
// reference trace/latency model, lock and reset corner cases.
module tb_ccc_reconfig_ctrl;

  localparam int NP = 4;
  localparam int EW = 4;
  localparam int NE = 16;
  localparam int LS = 16;
  localparam int LT = 200;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ;
  logic [1:0]  PROFILE;
  logic        BUSY, DONE, ERR, LOCK_LOST, FABRIC_RST;
  logic [5:0]  TBL_ADDR;
  logic [14:0] TBL_DATA;
  logic        CCC_PSEL, CCC_PENABLE, CCC_PWRITE;
  logic [5:0]  CCC_PADDR;
  logic [7:0]  CCC_PWDATA, CCC_PRDATA;
  logic        CCC_PRESET_N, CCC_PLL_ARST_N, CCC_LOCK;

  always #5 CLK = ~CLK;

  ccc_reconfig_ctrl #(
    .NUM_PROFILES(NP),
    .ENTRY_W     (EW),
    .VERIFY      (1),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .REQ           (REQ),
    .PROFILE       (PROFILE),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR           (ERR),
    .LOCK_LOST     (LOCK_LOST),
    .FABRIC_RST    (FABRIC_RST),
    .TBL_ADDR      (TBL_ADDR),
    .TBL_DATA      (TBL_DATA),
    .CCC_PSEL      (CCC_PSEL),
    .CCC_PENABLE   (CCC_PENABLE),
    .CCC_PWRITE    (CCC_PWRITE),
    .CCC_PADDR     (CCC_PADDR),
    .CCC_PWDATA    (CCC_PWDATA),
    .CCC_PRDATA    (CCC_PRDATA),
    .CCC_PRESET_N  (CCC_PRESET_N),
    .CCC_PLL_ARST_N(CCC_PLL_ARST_N),
    .CCC_LOCK      (CCC_LOCK)
  );

  logic [14:0] tbl [NP][NE];
  logic [7:0]  regs [64];
  logic [22:0] obs [$];
  logic        lock_en;
  int          corrupt_idx = 100;
  int          wr_cnt, apb_cnt, done_cnt, arst_bad;
  int          cyc, req_cyc;
  int          n_tests, n_fail;

  // Synchronous table ROM and a PLL that locks once released.
  always @(posedge CLK)
    TBL_DATA <= tbl[TBL_ADDR[5:4]][TBL_ADDR[3:0]];

  assign CCC_LOCK   = CCC_PLL_ARST_N & lock_en;
  assign CCC_PRDATA = regs[CCC_PADDR] ^
                      ((wr_cnt == corrupt_idx + 1) ? 8'h01 : 8'h00);

  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (CCC_PSEL && CCC_PLL_ARST_N) arst_bad++;
    if (CCC_PSEL && CCC_PENABLE) begin
      apb_cnt++;
      obs.push_back({CCC_PWRITE, CCC_PADDR,
                     CCC_PWRITE ? CCC_PWDATA : CCC_PRDATA});
      if (CCC_PWRITE) begin
        regs[CCC_PADDR] = CCC_PWDATA;
        wr_cnt++;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  function automatic int n_entries(input int p);
    for (int i = 0; i < NE; i++)
      if (tbl[p][i][14]) return i + 1;
    return NE;
  endfunction

  task automatic issue_req(input int p);
    PROFILE  = 2'(p);
    REQ      = 1'b1;
    obs.delete();
    wr_cnt   = 0;
    apb_cnt  = 0;
    done_cnt = 0;
    tick();
    REQ      = 1'b0;
    req_cyc  = cyc;
  endtask

  task automatic wait_sig(input bit want_err, output int lat);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      if (want_err ? ERR : DONE) seen = 1;
    end
    lat = cyc - req_cyc;
    chk(want_err ? "wait_err" : "wait_done", 32'(seen), 1);
  endtask

  task automatic check_trace(input int p);
    int n = n_entries(p);
    chk("trace_len", obs.size(), 2 * n);
    for (int i = 0; i < n && 2 * i + 1 < obs.size(); i++) begin
      chk("trace_wr", 32'(obs[2*i]),
          {9'd0, 1'b1, tbl[p][i][13:0]});
      chk("trace_rd", 32'(obs[2*i+1]),
          {9'd0, 1'b0, tbl[p][i][13:0]});
    end
  endtask

  task automatic run_ok(input int p, input bit poke);
    int lat;
    issue_req(p);
    if (poke) begin
      tick(); tick(); tick();
      PROFILE = PROFILE ^ 2'd1;
      REQ = 1'b1;
      tick();
      REQ = 1'b0;
    end
    wait_sig(1'b0, lat);
    chk("done_lat", lat, 1 + 5 * n_entries(p) + LS + 2);
    check_trace(p);
    tick();
    chk("done_once", done_cnt, 1);
    chk("run_fabric", {31'd0, FABRIC_RST}, 0);
  endtask

  task automatic reset_check();
    int  n = 0;
    RESET   = 1'b1;
    REQ     = 1'b0;
    lock_en = 1'b1;
    tick(); tick();
    chk("rst_fabric", {31'd0, FABRIC_RST}, 1);
    chk("rst_arst", {31'd0, CCC_PLL_ARST_N}, 1);
    chk("rst_preset", {31'd0, CCC_PRESET_N}, 0);
    chk("rst_apb", {9'd0, CCC_PSEL, CCC_PENABLE, CCC_PWRITE,
                    CCC_PADDR, CCC_PWDATA}, 0);
    chk("rst_flags", {29'd0, DONE, ERR, LOCK_LOST}, 0);
    done_cnt = 0;
    apb_cnt  = 0;
    RESET    = 1'b0;
    for (int i = 0; i < LS + 20; i++) begin
      tick();
      n++;
      if (i == 0) chk("preset_rel", {31'd0, CCC_PRESET_N}, 1);
      if (!FABRIC_RST) break;
    end
    chk("rst_lock_lat", n, LS + 2);
    tick(); tick();
    chk("rst_done_once", done_cnt, 1);
    chk("rst_no_apb", apb_cnt, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
  endtask

  initial begin
    int lat, p, g;
    int len [NP];
    REQ = 1'b0;
    PROFILE = '0;
    RESET = 1'b1;
    lock_en = 1'b1;
    for (int i = 0; i < 64; i++) regs[i] = '0;
    len[0] = NE;
    len[1] = $urandom_range(6, 10);
    len[2] = 3;
    len[3] = $urandom_range(1, 5);
    for (int q = 0; q < NP; q++)
      for (int i = 0; i < NE; i++) begin
        if (i < len[q])
          tbl[q][i] = {(q != 0 && i == len[q] - 1),
                       6'($urandom), 8'($urandom)};
        else
          tbl[q][i] = 15'($urandom);
      end
    tbl[1][1][7:0] = 8'hA5;

    reset_check();

    run_ok(2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      p = $urandom_range(0, NP - 1);
      run_ok(p, 1'b1);
    end

    // Readback mismatch on entry 1 of profile 1.
    corrupt_idx = 1;
    issue_req(1);
    wait_sig(1'b1, lat);
    chk("mis_lat", lat, 1 + 5 * 2);
    chk("mis_arst", {31'd0, CCC_PLL_ARST_N}, 1);
    chk("mis_fabric", {31'd0, FABRIC_RST}, 1);
    chk("mis_idle", {29'd0, CCC_PSEL, CCC_PENABLE, BUSY}, 0);
    chk("mis_len", obs.size(), 4);
    if (obs.size() == 4) chk("mis_rd", 32'(obs[3][7:0]), 8'hA4);
    corrupt_idx = 100;

    // Lock never returns: timeout, then recovery.
    lock_en = 1'b0;
    issue_req(3);
    wait_sig(1'b1, lat);
    chk("tmo_lat", lat, 1 + 5 * n_entries(3) + LT);
    lock_en = 1'b1;
    run_ok(3, 1'b0);

    // One-cycle lock glitch while running.
    tick(); tick();
    apb_cnt  = 0;
    done_cnt = 0;
    lock_en  = 1'b0;
    tick();
    lock_en  = 1'b1;
    g = cyc;
    tick(); tick();
    chk("glitch_lost", {31'd0, LOCK_LOST}, 1);
    chk("glitch_fabric", {31'd0, FABRIC_RST}, 1);
    req_cyc = g;
    wait_sig(1'b0, lat);
    chk("glitch_relock", lat, LS + 2);
    chk("glitch_no_apb", apb_cnt, 0);
    chk("glitch_sticky", {31'd0, LOCK_LOST}, 1);

    // REQ in the same cycle the synced lock drops.
    lock_en = 1'b0;
    tick(); tick();
    issue_req(2);
    lock_en = 1'b1;
    chk("race_lost", {31'd0, LOCK_LOST}, 0);
    chk("race_hold", {30'd0, BUSY, CCC_PLL_ARST_N}, 2);
    wait_sig(1'b0, lat);
    chk("race_lat", lat, 1 + 5 * 3 + LS + 2);

    // Asynchronous reset during the ACCESS of entry 5.
    issue_req(0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (CCC_PENABLE && CCC_PWRITE && wr_cnt == 5) break;
    end
    chk("mid_in_access", {30'd0, CCC_PENABLE, CCC_PWRITE}, 3);
    #2 RESET = 1'b1;
    #1;
    chk("mid_apb", {9'd0, CCC_PSEL, CCC_PENABLE, CCC_PWRITE,
                    CCC_PADDR, CCC_PWDATA}, 0);
    chk("mid_arst", {31'd0, CCC_PLL_ARST_N}, 1);
    chk("mid_fabric", {31'd0, FABRIC_RST}, 1);
    reset_check();

    chk("arst_low_in_xfer", arst_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
